led_pattern_seq: RTL

Pattern sequencer for the 8-LED flasher, directly downstream of the clock divider. It runs entirely in the system clock domain and treats the divider's slow square-wave output as a step strobe, advancing one pattern step per rising edge of that strobe. It drives the board LED bank in one of four selectable display modes and flags each completed pattern period.

---
 rtl/led_seq_pkg.sv | 25 ++
 rtl/led_pattern_seq_if.sv | 21 ++
 rtl/rise_detect.sv | 18 +
 rtl/led_pattern_seq.sv | 85 ++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
// Holds the mode encodings and the per-mode start pattern.
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_SHIFT_L = 2'b00,
      MODE_SHIFT_R = 2'b01,
      MODE_BOUNCE  = 2'b10,
      MODE_BAR     = 2'b11
   } mode_t;

   // Start pattern of each mode for an n-LED bank (n in 2..32).
   function automatic logic [31:0] start_pat(mode_t m, int unsigned n);
      logic [31:0] r;
      r = 32'd0;
      unique case (m)
         MODE_SHIFT_L: r = 32'd1;
         MODE_SHIFT_R: r = 32'd1 << (n - 1);
         MODE_BOUNCE:  r = 32'd1;
         MODE_BAR:     r = 32'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// Control/display bundle of the LED pattern sequencer.
// master: step_in, mode, pause out; led, wrap in. slave: the reverse.
interface led_pattern_seq_if #(
   parameter int N_LED = 8
);
   logic             step_in;
   logic [1:0]       mode;
   logic             pause;
   logic [N_LED-1:0] led;
   logic             wrap;

   modport master (
      output step_in, mode, pause,
      input  led, wrap
   );

   modport slave (
      input  step_in, mode, pause,
      output led, wrap
   );
endinterface

// File: rtl/rise_detect.sv
// One-clk rising-edge pulse of a clk-synchronous level.
// Ports: clk, rst (sync, high), d (level), rise (pulse).
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);
   logic d_q;

   // Reset high so a level already high at release is not an edge.
   always_ff @(posedge clk) begin
      if (rst) d_q <= 1'b1;
      else     d_q <= d;
   end

   assign rise = d & ~d_q;
endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: shift-left/right, bounce and bar modes,
// stepped by rising edges of step_in, with a wrap pulse per period.
// Ports: clk, rst (sync, high), bus (slave: step_in, mode, pause,
// led, wrap). LED_ACTIVE_LOW_EN defined: led = ~pattern.
module led_pattern_seq
   import led_seq_pkg::*;
#(
   parameter int N_LED = 8
) (
   input  logic                clk,
   input  logic                rst,
   led_pattern_seq_if.slave    bus
);
   localparam logic [N_LED-1:0] LSB = N_LED'(1);

   logic             step_rise;
   logic [N_LED-1:0] pat;
   logic [N_LED-1:0] nxt;
   logic [N_LED-1:0] s_new;
   logic [N_LED-1:0] s_cur;
   logic             dir;
   logic             nxt_dir;
   logic             wrap_q;
   mode_t            mode_q;
   mode_t            mode_in;

   rise_detect u_rise (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.step_in),
      .rise (step_rise)
   );

   assign mode_in = mode_t'(bus.mode);
   assign s_new   = N_LED'(start_pat(mode_in, N_LED));
   assign s_cur   = N_LED'(start_pat(mode_q, N_LED));

   always_comb begin
      nxt     = pat;
      nxt_dir = dir;
      unique case (mode_q)
         MODE_SHIFT_L: nxt = {pat[N_LED-2:0], pat[N_LED-1]};
         MODE_SHIFT_R: nxt = {pat[0], pat[N_LED-1:1]};
         MODE_BOUNCE: begin
            // Turn around when the lit bit reaches either end.
            if (!dir) begin
               nxt     = pat << 1;
               nxt_dir = nxt[N_LED-1];
            end else begin
               nxt     = pat >> 1;
               nxt_dir = ~nxt[0];
            end
         end
         MODE_BAR: nxt = (&pat) ? '0 : {pat[N_LED-2:0], 1'b1};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pat    <= LSB;
         dir    <= 1'b0;
         mode_q <= MODE_SHIFT_L;
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         // A mode change wins over a coincident step.
         if (mode_in != mode_q) begin
            pat    <= s_new;
            dir    <= 1'b0;
            mode_q <= mode_in;
         end else if (step_rise && !bus.pause) begin
            pat    <= nxt;
            dir    <= nxt_dir;
            wrap_q <= (nxt == s_cur);
         end
      end
   end

`ifdef LED_ACTIVE_LOW_EN
   assign bus.led = ~pat;
`else
   assign bus.led = pat;
`endif
   assign bus.wrap = wrap_q;
endmodule
